// File: rtl/morse_stream_decoder.sv
// Morse key stream decoder: times marks and gaps, classifies dots/dashes,
// decodes letters to ASCII and queues them in a first-word-fall-through FIFO.
module morse_stream_decoder #(
  parameter int TICKS_PER_UNIT   = 5_000_000,
  parameter int DASH_UNITS       = 2,
  parameter int LETTER_GAP_UNITS = 2,
  parameter int WORD_GAP_UNITS   = 5,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          key,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          dot_pulse,
  output logic                          dash_pulse,
  output logic [5:0]                    sym_bits,
  output logic [2:0]                    sym_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int WORD_T = WORD_GAP_UNITS * TICKS_PER_UNIT;
  localparam int DW     = $clog2(WORD_T + 1);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;

  localparam logic [DW-1:0] WORD_V   = DW'(WORD_T);
  localparam logic [DW-1:0] LETTER_V = DW'(LETTER_GAP_UNITS * TICKS_PER_UNIT);
  localparam logic [DW-1:0] ONE_V    = DW'(1);
  localparam logic [31:0]   DASH_T   = 32'(DASH_UNITS * TICKS_PER_UNIT);
  localparam logic [CW-1:0] FULL_V   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    GAP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   dur;
  logic [DW-1:0]   dur_inc;
  logic            key_edge;
  logic            is_dash;
  logic            letter_done;
  logic            word_done;
  logic            emit;
  logic [7:0]      emit_ch;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic            full;
  logic            rd;
  logic            wr;

  function automatic logic [7:0] decode(
    input logic [2:0] n,
    input logic [5:0] b
  );
    logic [7:0] ch;
    // element 0 sits in bit 0; 1 = dash
    case ({n, b})
      {3'd2, 6'd2}:  ch = 8'h41;
      {3'd4, 6'd1}:  ch = 8'h42;
      {3'd4, 6'd5}:  ch = 8'h43;
      {3'd3, 6'd1}:  ch = 8'h44;
      {3'd1, 6'd0}:  ch = 8'h45;
      {3'd4, 6'd4}:  ch = 8'h46;
      {3'd3, 6'd3}:  ch = 8'h47;
      {3'd4, 6'd0}:  ch = 8'h48;
      {3'd2, 6'd0}:  ch = 8'h49;
      {3'd4, 6'd14}: ch = 8'h4A;
      {3'd3, 6'd5}:  ch = 8'h4B;
      {3'd4, 6'd2}:  ch = 8'h4C;
      {3'd2, 6'd3}:  ch = 8'h4D;
      {3'd2, 6'd1}:  ch = 8'h4E;
      {3'd3, 6'd7}:  ch = 8'h4F;
      {3'd4, 6'd6}:  ch = 8'h50;
      {3'd4, 6'd11}: ch = 8'h51;
      {3'd3, 6'd2}:  ch = 8'h52;
      {3'd3, 6'd0}:  ch = 8'h53;
      {3'd1, 6'd1}:  ch = 8'h54;
      {3'd3, 6'd4}:  ch = 8'h55;
      {3'd4, 6'd8}:  ch = 8'h56;
      {3'd3, 6'd6}:  ch = 8'h57;
      {3'd4, 6'd9}:  ch = 8'h58;
      {3'd4, 6'd13}: ch = 8'h59;
      {3'd4, 6'd3}:  ch = 8'h5A;
      {3'd5, 6'd31}: ch = 8'h30;
      {3'd5, 6'd30}: ch = 8'h31;
      {3'd5, 6'd28}: ch = 8'h32;
      {3'd5, 6'd24}: ch = 8'h33;
      {3'd5, 6'd16}: ch = 8'h34;
      {3'd5, 6'd0}:  ch = 8'h35;
      {3'd5, 6'd1}:  ch = 8'h36;
      {3'd5, 6'd3}:  ch = 8'h37;
      {3'd5, 6'd7}:  ch = 8'h38;
      {3'd5, 6'd15}: ch = 8'h39;
      default:       ch = 8'h3F;
    endcase
    return ch;
  endfunction

  assign dur_inc  = (dur == WORD_V) ? dur : dur + ONE_V;
  assign key_edge = key != (state == MARK);
  assign is_dash  = 32'(dur) >= DASH_T;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    dot_pulse   = 1'b0;
    dash_pulse  = 1'b0;
    letter_done = 1'b0;
    word_done   = 1'b0;
    case (state)
      IDLE: begin
        if (key) state_nxt = MARK;
      end
      MARK: begin
        if (!key) begin
          state_nxt  = GAP;
          dash_pulse = is_dash;
          dot_pulse  = !is_dash;
        end
      end
      GAP: begin
        if (key) begin
          state_nxt = MARK;
        end else if (dur_inc == WORD_V) begin
          word_done = 1'b1;
          state_nxt = IDLE;
        end else if (dur_inc == LETTER_V && sym_count != 3'd0) begin
          letter_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign emit    = letter_done || word_done;
  assign emit_ch = word_done ? 8'h20 : decode(sym_count, sym_bits);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dur       <= '0;
      sym_bits  <= '0;
      sym_count <= '0;
    end else begin
      dur <= key_edge ? ONE_V : dur_inc;
      if (letter_done) begin
        sym_bits  <= '0;
        sym_count <= '0;
      end else if (dot_pulse || dash_pulse) begin
        // shifts past bit 5 fall off, so a 7th element changes nothing
        sym_bits <= sym_bits | (6'(dash_pulse) << sym_count);
        if (sym_count != 3'd7) sym_count <= sym_count + 3'd1;
      end
    end
  end

  assign full    = fifo_count == FULL_V;
  assign m_valid = fifo_count != '0;
  assign m_data  = m_valid ? mem[rptr] : 8'h00;
  assign rd      = m_valid && m_ready;
  assign wr      = emit && (!full || rd);

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= emit_ch;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) rptr <= rptr + AW'(1);
      case ({wr, rd})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (emit && full && !rd) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_morse_stream_decoder.sv
// Scoreboard bench for morse_stream_decoder: stimulus queues expected
// characters, a negedge monitor checks every FIFO read against them.
module tb_morse_stream_decoder;

  localparam int TPU   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key = 1'b0;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       dot_pulse;
  logic       dash_pulse;
  logic [5:0] sym_bits;
  logic [2:0] sym_count;
  logic [2:0] fifo_count;
  logic       overflow;

  int         total = 0;
  int         bad = 0;
  int         pulses = 0;
  logic [7:0] exp_q[$];

  morse_stream_decoder #(
    .TICKS_PER_UNIT(TPU),
    .DASH_UNITS(2),
    .LETTER_GAP_UNITS(2),
    .WORD_GAP_UNITS(5),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key(key),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .dot_pulse(dot_pulse),
    .dash_pulse(dash_pulse),
    .sym_bits(sym_bits),
    .sym_count(sym_count),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (dot_pulse || dash_pulse) pulses++;
    if (!reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read: got %0h want none", m_data);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", {24'd0, m_data}, {24'd0, e});
      end
    end
  end

  task automatic cyc(input logic k, input int n);
    key = k;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic letter(input string p, input logic [7:0] ch,
                        input bit push);
    for (int i = 0; i < p.len(); i++) begin
      cyc(1'b1, (p[i] == 8'h2D) ? 12 : 4);
      cyc(1'b0, (i == p.len() - 1) ? 8 : 4);
    end
    if (push) exp_q.push_back(ch);
  endtask

  task automatic drain();
    int n;
    n = 0;
    m_ready = 1'b1;
    while (m_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    m_ready = 1'b0;
    check("drain_empty", m_valid, 0);
    check("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    int p0;
    #1;
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_symc", sym_count, 0);
    check("rst_symb", sym_bits, 0);
    check("rst_pulse", {dot_pulse, dash_pulse}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // letter A with precise emit timing
    cyc(1'b1, 4);
    key = 1'b0;
    @(negedge clk);
    check("a_dot", dot_pulse, 1);
    check("a_nodash", dash_pulse, 0);
    @(posedge clk);
    #1;
    cyc(1'b0, 3);
    cyc(1'b1, 12);
    key = 1'b0;
    @(negedge clk);
    check("a_dash", dash_pulse, 1);
    @(posedge clk);
    #1;
    check("a_bits", sym_bits, 6'b000010);
    check("a_cnt", sym_count, 2);
    cyc(1'b0, 6);
    @(negedge clk);
    check("a_valid_early", m_valid, 0);
    @(posedge clk);
    #1;
    check("a_valid", m_valid, 1);
    check("a_head", m_data, 8'h41);
    check("a_clr", sym_count, 0);
    exp_q.push_back(8'h41);
    cyc(1'b0, 12);
    exp_q.push_back(8'h20);
    cyc(1'b0, 10);
    check("a_space_once", fifo_count, 2);
    drain();

    // SOS then word gap
    letter("...", 8'h53, 1'b1);
    letter("---", 8'h4F, 1'b1);
    letter("...", 8'h53, 1'b1);
    cyc(1'b0, 12);
    exp_q.push_back(8'h20);
    check("sos_count", fifo_count, 4);
    check("sos_ovf", overflow, 0);
    drain();

    // seven dots saturate and decode as '?'
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 4);
      cyc(1'b0, (i == 6) ? 1 : 4);
    end
    check("long_cnt", sym_count, 7);
    check("long_bits", sym_bits, 0);
    cyc(1'b0, 7);
    exp_q.push_back(8'h3F);
    cyc(1'b0, 12);
    exp_q.push_back(8'h20);
    drain();

    // overflow: five E with no reader
    for (int i = 0; i < 5; i++) letter(".", 8'h45, i < 4);
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", overflow, 1);
    cyc(1'b0, 12);
    drain();
    check("ovf_sticky", overflow, 1);
    check("ovf_count0", fifo_count, 0);

    // reset during a mark that ends inside reset
    p0 = pulses;
    cyc(1'b1, 3);
    reset = 1'b1;
    #1;
    check("mr_ovf", overflow, 0);
    check("mr_symc", sym_count, 0);
    cyc(1'b1, 3);
    cyc(1'b0, 1);
    reset = 1'b0;
    cyc(1'b0, 30);
    check("mr_pulses", pulses - p0, 0);
    check("mr_valid", m_valid, 0);
    check("mr_count", fifo_count, 0);
    check("mr_data", m_data, 0);

    // key already high at reset release starts a new mark
    reset = 1'b1;
    cyc(1'b1, 1);
    reset = 1'b0;
    cyc(1'b1, 4);
    cyc(1'b0, 8);
    exp_q.push_back(8'h45);
    cyc(1'b0, 12);
    exp_q.push_back(8'h20);
    check("held_count", fifo_count, 2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/morse_stream_decoder.md
MORSE_STREAM_DECODER -- requirements
Module: morse_stream_decoder

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- TICKS_PER_UNIT, 5_000_000, clk cycles per Morse time unit.
- DASH_UNITS, 2, minimum mark length in units that counts as a dash.
- LETTER_GAP_UNITS, 2, space length in units that ends a letter.
- WORD_GAP_UNITS, 5, space length in units that ends a word; must exceed LETTER_GAP_UNITS.
- FIFO_DEPTH, 16, output FIFO entries; power of 2, at least 2.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, asynchronous, active-high; clears all state.
- key, in, 1, debounced Morse key level, synchronous to clk; 1 = mark.
- m_data, out, 8, ASCII character at the FIFO head.
- m_valid, out, 1, FIFO not empty.
- m_ready, in, 1, consumer accepts m_data when m_valid is high.
- dot_pulse, out, 1, one-cycle strobe when a dot is classified.
- dash_pulse, out, 1, one-cycle strobe when a dash is classified.
- sym_bits, out, 6, elements of the current letter; element i at bit i; 1 = dash.
- sym_count, out, 3, number of elements in the current letter, 0..7 (saturating).
- fifo_count, out, clog2(FIFO_DEPTH)+1, FIFO occupancy.
- overflow, out, 1, sticky flag: a character was dropped because the FIFO was full.

Function
REQ-003 The block SHALL use a 3-state FSM: IDLE, MARK, GAP.
- IDLE: key low, no letter pending.
- MARK: key high.
- GAP: key low after at least one element.
REQ-004 Duration counter dur:
- dur SHALL clear on every key edge and increment each cycle.
- dur SHALL saturate at WORD_GAP_UNITS*TICKS_PER_UNIT.
REQ-005 IDLE, key=1: next state MARK, dur=1.
REQ-006 MARK, key=0:
- If dur >= DASH_UNITS*TICKS_PER_UNIT, the element is a dash; otherwise it is a dot.
- Assert dash_pulse or dot_pulse for that cycle.
- Store the element at bit position sym_count (when sym_count < 6).
- Increment sym_count, saturating at 7.
- Next state GAP.
REQ-007 GAP, key=1: next state MARK; pending letter is kept.
REQ-008 GAP, dur reaches LETTER_GAP_UNITS*TICKS_PER_UNIT with sym_count > 0:
- Emit the decoded character in that same cycle.
- Clear sym_bits and sym_count.
- Remain in GAP.
REQ-009 GAP, dur reaches WORD_GAP_UNITS*TICKS_PER_UNIT:
- Emit 0x20 exactly once.
- Next state IDLE.
REQ-010 Decode table (combinational), ITU Morse:
- A-Z as uppercase 0x41-0x5A.
- 0-9 as 0x30-0x39.
- Any unlisted pattern, or sym_count = 7 (more than 6 elements), SHALL emit '?' (0x3F).
REQ-011 FIFO:
- First-word-fall-through.
- An emitted character is written at the next clk edge; m_valid rises 1 cycle after the emit cycle when the FIFO was empty.
REQ-012 A read SHALL occur when m_valid && m_ready.
- m_data and fifo_count SHALL update on the same edge as the read.
REQ-013 If the FIFO is full and no read occurs in the same cycle, the emitted character SHALL be dropped and overflow set.
- Simultaneous read and write while full SHALL accept the write; fifo_count is unchanged.
REQ-014 Simultaneous read and write while empty: the read is ignored and the write is accepted.
REQ-015 Pointers SHALL wrap modulo FIFO_DEPTH.
- fifo_count SHALL never exceed FIFO_DEPTH or go below 0.
REQ-016 Timing counter width SHALL be clog2(WORD_GAP_UNITS*TICKS_PER_UNIT+1).
- No counter wrap-around is permitted.

Reset
REQ-017 While reset=1, the following SHALL hold immediately and asynchronously:
- state=IDLE, dur=0.
- sym_bits=0, sym_count=0.
- FIFO empty, fifo_count=0, m_valid=0, m_data=0x00.
- dot_pulse=0, dash_pulse=0, overflow=0.
REQ-018 A reset asserted mid-letter or mid-mark SHALL discard the partial letter and emit nothing.
- After reset deassertion, a key already held high SHALL be treated as a new mark starting in IDLE.

Verification (TICKS_PER_UNIT=4, FIFO_DEPTH=4)
REQ-019 Letter 'A' with gap expiry:
- Stimulus: key high 4 cycles, low 4, high 12, low 8.
- Response: dot_pulse, then dash_pulse; sym_bits=000010, sym_count=2.
- Response: 0x41 emitted at low count 8; m_valid=1 one cycle later.
REQ-020 'SOS', then word gap:
- Stimulus: S, O, S with 8-cycle letter gaps, then key low 20 cycles.
- Response: FIFO holds 0x53, 0x4F, 0x53, 0x20; fifo_count=4.
REQ-021 Overlong pattern:
- Stimulus: 7 dots, then an 8-cycle gap.
- Response: sym_count saturates at 7; 0x3F emitted.
REQ-022 FIFO overflow with m_ready=0:
- Stimulus: 5 letters 'E' (one dot each).
- Response: 4 stored, overflow=1.
- Then m_ready=1 for 4 cycles: 0x45 read 4 times, m_valid=0, overflow stays 1.
REQ-023 Reset mid-mark:
- Stimulus: assert reset during a 6-cycle mark, release, key low 30 cycles.
- Response: no emit, m_valid=0, all outputs at reset values.
